param_bus_datapath: RTL and testbench

// - Parametrised successor of the phase-2 single-bus datapath: NUM_REGS x DATA_W register file, HI/LO/Y/Z/PC/IR, MAR/MDR, in/out ports, CON flag.
// - Adds an encoded bus-source select and a handshaked, wait-state-tolerant memory interface with timeout, replacing fixed-latency memory.
// - The ALU and IR decode are external; the control unit drives all select/load strobes.

---
 rtl/dp_pkg.sv | 51 +++++
 rtl/dp_mem_if.sv | 111 +++++++++++
 rtl/param_bus_datapath.sv | 170 +++++++++++++++++
 tb/tb_param_bus_datapath.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared encodings for the parametrised single-bus datapath: bus-source offsets,
// load-strobe bit positions, branch condition codes and memory FSM states.
package dp_pkg;

    // Special bus sources sit directly above the last general register.
    localparam int SRC_HI     = 0;
    localparam int SRC_LO     = 1;
    localparam int SRC_ZHI    = 2;
    localparam int SRC_ZLO    = 3;
    localparam int SRC_PC     = 4;
    localparam int SRC_MDR    = 5;
    localparam int SRC_INPORT = 6;
    localparam int SRC_CEXT   = 7;

    localparam int LD_Z   = 0;
    localparam int LD_HI  = 1;
    localparam int LD_LO  = 2;
    localparam int LD_Y   = 3;
    localparam int LD_PC  = 4;
    localparam int LD_MAR = 5;
    localparam int LD_MDR = 6;
    localparam int LD_OUT = 7;
    localparam int LD_IR  = 8;

    localparam int IR_COND_LSB = 19;

    typedef enum logic [1:0] {
        COND_ZERO    = 2'b00,
        COND_NONZERO = 2'b01,
        COND_POS     = 2'b10,
        COND_NEG     = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_REQ  = 2'b01,
        MEM_DONE = 2'b10,
        MEM_ERR  = 2'b11
    } mem_state_e;

    function automatic logic cond_met(input cond_e c, input logic is_zero, input logic is_neg);
        case (c)
            COND_ZERO:    return is_zero;
            COND_NONZERO: return !is_zero;
            COND_POS:     return !is_neg;
            COND_NEG:     return is_neg;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dp_mem_if.sv
// Handshaked memory port: owns MAR/MDR and runs one request at a time with an
// ack timeout that raises a sticky error.
module dp_mem_if
    import dp_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              mem_err
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        we_d    = we_q;
        err_d   = err_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;

        case (state_q)
            MEM_IDLE: begin
                if (mem_rd && mem_wr) begin
                    err_d = 1'b1;
                end else if (mem_rd ^ mem_wr) begin
                    state_d = MEM_REQ;
                    we_d    = mem_wr;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            MEM_REQ: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d = MEM_DONE;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = MEM_ERR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            MEM_ERR:  state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase

        // Address and write data are frozen while a request is outstanding.
        if (state_q != MEM_REQ) begin
            if (ld_mar) begin
                mar_d = bus_in[ADDR_W-1:0];
            end
            if (ld_mdr) begin
                mdr_d = bus_in;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= MEM_IDLE;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            err_q   <= err_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    assign mem_req   = (state_q == MEM_REQ);
    assign busy      = (state_q == MEM_REQ);
    assign mem_we    = (state_q == MEM_REQ) && we_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mem_err   = err_q;

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus datapath: general register file, HI/LO/Y/Z/PC/IR, ports and CON flag,
// with the memory interface delegated to dp_mem_if.
module param_bus_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 9,
    parameter int PC_STEP     = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [5:0]          src_sel,
    input  logic [NUM_REGS-1:0] reg_ld,
    input  logic [8:0]          ld_ctl,
    input  logic                inc_pc,
    input  logic                ba_out,
    input  logic                con_in,
    input  logic                mem_rd,
    input  logic                mem_wr,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [DATA_W-1:0]   alu_y,
    input  logic [DATA_W-1:0]   alu_zhi,
    input  logic [DATA_W-1:0]   alu_zlo,
    input  logic [DATA_W-1:0]   c_ext,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic [DATA_W-1:0]   bus,
    output logic [DATA_W-1:0]   ir,
    output logic                con,
    output logic                busy,
    output logic                mem_err
);

    localparam int RSEL_W = $clog2(NUM_REGS);
    localparam logic [5:0] SRC_BASE = 6'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] zhi_q, zhi_d;
    logic [DATA_W-1:0] zlo_q, zlo_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] inport_q, inport_d;
    logic              con_q, con_d;

    logic [DATA_W-1:0] bus_val;
    logic [DATA_W-1:0] mdr_val;
    logic [5:0]        src_ofs;

    always_comb begin
        bus_val = '0;
        src_ofs = src_sel - SRC_BASE;
        if (src_sel < SRC_BASE) begin
            if (!(ba_out && src_sel == 6'd0)) begin
                bus_val = regs_q[src_sel[RSEL_W-1:0]];
            end
        end else begin
            case (src_ofs)
                6'(SRC_HI):     bus_val = hi_q;
                6'(SRC_LO):     bus_val = lo_q;
                6'(SRC_ZHI):    bus_val = zhi_q;
                6'(SRC_ZLO):    bus_val = zlo_q;
                6'(SRC_PC):     bus_val = pc_q;
                6'(SRC_MDR):    bus_val = mdr_val;
                6'(SRC_INPORT): bus_val = inport_q;
                6'(SRC_CEXT):   bus_val = c_ext;
                default:        bus_val = '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = reg_ld[i] ? bus_val : regs_q[i];
        end
    end

    always_comb begin
        hi_d     = ld_ctl[LD_HI]  ? bus_val : hi_q;
        lo_d     = ld_ctl[LD_LO]  ? bus_val : lo_q;
        y_d      = ld_ctl[LD_Y]   ? bus_val : y_q;
        ir_d     = ld_ctl[LD_IR]  ? bus_val : ir_q;
        out_d    = ld_ctl[LD_OUT] ? bus_val : out_q;
        zhi_d    = ld_ctl[LD_Z]   ? alu_zhi : zhi_q;
        zlo_d    = ld_ctl[LD_Z]   ? alu_zlo : zlo_q;
        inport_d = in_port;

        pc_d = pc_q;
        if (ld_ctl[LD_PC]) begin
            pc_d = bus_val;
        end else if (inc_pc) begin
            pc_d = pc_q + DATA_W'(PC_STEP);
        end

        // The condition field is taken from the IR as it stood before this edge.
        con_d = con_q;
        if (con_in) begin
            con_d = cond_met(cond_e'(ir_q[IR_COND_LSB +: 2]), bus_val == '0, bus_val[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            regs_q   <= '{default: '0};
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            zhi_q    <= '0;
            zlo_q    <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            out_q    <= '0;
            inport_q <= '0;
            con_q    <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            zhi_q    <= zhi_d;
            zlo_q    <= zlo_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            out_q    <= out_d;
            inport_q <= inport_d;
            con_q    <= con_d;
        end
    end

    dp_mem_if #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_if (
        .clk       (clk),
        .clr       (clr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ld_mar    (ld_ctl[LD_MAR]),
        .ld_mdr    (ld_ctl[LD_MDR]),
        .bus_in    (bus_val),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mdr_val),
        .busy      (busy),
        .mem_err   (mem_err)
    );

    assign mem_wdata = mdr_val;
    assign bus       = bus_val;
    assign ir        = ir_q;
    assign alu_y     = y_q;
    assign out_port  = out_q;
    assign con       = con_q;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Scoreboard bench for param_bus_datapath: stimulus pushes expectations from a
// behavioural model, a negedge monitor pops and compares them.
module tb_param_bus_datapath;
    import dp_pkg::*;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 9;
    localparam int TMO = 15;

    localparam int K_BUS = 0, K_CON = 1, K_BUSY = 2, K_REQ = 3, K_WE = 4, K_ERR = 5;
    localparam int K_ADDR = 6, K_WDATA = 7, K_Y = 8, K_OUT = 9, K_IR = 10;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [5:0]    src_sel = '0;
    logic [NR-1:0] reg_ld = '0;
    logic [8:0]    ld_ctl = '0;
    logic          inc_pc = 1'b0, ba_out = 1'b0, con_in = 1'b0;
    logic          mem_rd = 1'b0, mem_wr = 1'b0, mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0, alu_zhi = '0, alu_zlo = '0, c_ext = '0, in_port = '0;
    logic          mem_req, mem_we, con, busy, mem_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, alu_y, out_port, bus, ir;

    always #5 clk = ~clk;

    param_bus_datapath dut (
        .clk(clk), .clr(clr), .src_sel(src_sel), .reg_ld(reg_ld), .ld_ctl(ld_ctl),
        .inc_pc(inc_pc), .ba_out(ba_out), .con_in(con_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_y(alu_y), .alu_zhi(alu_zhi),
        .alu_zlo(alu_zlo), .c_ext(c_ext), .in_port(in_port), .out_port(out_port),
        .bus(bus), .ir(ir), .con(con), .busy(busy), .mem_err(mem_err)
    );

    function automatic logic [5:0] sc(input int ofs);
        return 6'(NR + ofs);
    endfunction

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_hi, m_lo, m_y, m_zhi, m_zlo, m_pc, m_ir, m_out, m_mdr, m_inport;
    logic [AW-1:0] m_mar;
    logic          m_con, m_busy, m_err;

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_hi = '0; m_lo = '0; m_y = '0; m_zhi = '0; m_zlo = '0; m_pc = '0;
        m_ir = '0; m_out = '0; m_mdr = '0; m_inport = '0; m_mar = '0;
        m_con = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_bus(input logic [5:0] s, input logic ba);
        if (int'(s) < NR) return (s == 6'd0 && ba) ? '0 : m_regs[s[3:0]];
        case (int'(s) - NR)
            SRC_HI:     return m_hi;
            SRC_LO:     return m_lo;
            SRC_ZHI:    return m_zhi;
            SRC_ZLO:    return m_zlo;
            SRC_PC:     return m_pc;
            SRC_MDR:    return m_mdr;
            SRC_INPORT: return m_inport;
            SRC_CEXT:   return c_ext;
            default:    return '0;
        endcase
    endfunction

    // Apply one clock edge to the model using the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic [DW-1:0] b;
        logic [1:0]    cnd;
        b   = model_bus(src_sel, ba_out);
        cnd = m_ir[20:19];
        for (int r = 0; r < NR; r++) if (reg_ld[r]) m_regs[r] = b;
        if (con_in) begin
            case (cnd)
                2'b00:   m_con = (b == 0);
                2'b01:   m_con = (b != 0);
                2'b10:   m_con = ($signed(b) >= 0);
                default: m_con = ($signed(b) < 0);
            endcase
        end
        if (ld_ctl[LD_HI])  m_hi  = b;
        if (ld_ctl[LD_LO])  m_lo  = b;
        if (ld_ctl[LD_Y])   m_y   = b;
        if (ld_ctl[LD_IR])  m_ir  = b;
        if (ld_ctl[LD_OUT]) m_out = b;
        if (ld_ctl[LD_Z]) begin m_zhi = alu_zhi; m_zlo = alu_zlo; end
        if (ld_ctl[LD_PC]) m_pc = b;
        else if (inc_pc)   m_pc = m_pc + 1;
        if (!m_busy && ld_ctl[LD_MAR]) m_mar = b[AW-1:0];
        if (!m_busy && ld_ctl[LD_MDR]) m_mdr = b;
        m_inport = in_port;
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic idle_strobes();
        reg_ld = '0; ld_ctl = '0; inc_pc = 1'b0; con_in = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    int            n_tests = 0;
    int            n_fail = 0;
    int            q_kind [$];
    logic [DW-1:0] q_val [$];
    string         q_name [$];
    int            busy_q [$];

    task automatic chk(input int kind, input logic [DW-1:0] val, input string name);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    function automatic logic [DW-1:0] actual(input int kind);
        case (kind)
            K_BUS:   return bus;
            K_CON:   return 32'(con);
            K_BUSY:  return 32'(busy);
            K_REQ:   return 32'(mem_req);
            K_WE:    return 32'(mem_we);
            K_ERR:   return 32'(mem_err);
            K_ADDR:  return 32'(mem_addr);
            K_WDATA: return mem_wdata;
            K_Y:     return alu_y;
            K_OUT:   return out_port;
            default: return ir;
        endcase
    endfunction

    initial begin : monitor
        int            k;
        logic [DW-1:0] v, a;
        string         nm;
        int            run;
        int            e;
        run = 0;
        forever begin
            @(negedge clk);
            while (q_kind.size() > 0) begin
                k = q_kind.pop_front(); v = q_val.pop_front(); nm = q_name.pop_front();
                a = actual(k);
                n_tests++;
                if (a !== v) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, a, v);
                end else begin
                    $display("[TB] ok %s = %h", nm, a);
                end
            end
            if (busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (busy_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL busy_run: got unexpected txn of %0d cycles expected none", run);
                end else begin
                    e = busy_q.pop_front();
                    if (e >= 0) begin
                        n_tests++;
                        if (run != e) begin
                            n_fail++;
                            $display("FAIL busy_run: got %0d cycles expected %0d", run, e);
                        end else begin
                            $display("[TB] ok busy_run = %0d cycles", run);
                        end
                    end
                end
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory helpers ----------------
    task automatic mem_txn(input logic wr, input logic [AW-1:0] addr, input int ws,
                           input logic [DW-1:0] data, input string tag);
        in_port = 32'(addr); tick();
        src_sel = sc(SRC_INPORT); ld_ctl = 9'(1 << LD_MAR); tick(); ld_ctl = '0;
        if (wr) begin
            in_port = data; tick();
            ld_ctl = 9'(1 << LD_MDR); tick(); ld_ctl = '0;
        end
        mem_rd = !wr; mem_wr = wr; tick(); mem_rd = 1'b0; mem_wr = 1'b0;
        m_busy = 1'b1; m_err = 1'b0;
        busy_q.push_back(ws + 1);
        for (int c = 0; c <= ws; c++) begin
            if (c == ws) begin mem_ack = 1'b1; mem_rdata = wr ? ~data : data; end
            if (c == 1) begin in_port = $urandom; ld_ctl = 9'((1 << LD_MAR) | (1 << LD_MDR)); end
            chk(K_BUSY, 1, {tag, "_busy"});
            chk(K_REQ, 1, {tag, "_req"});
            chk(K_WE, 32'(wr), {tag, "_we"});
            chk(K_ADDR, 32'(addr), {tag, "_addr_stable"});
            chk(K_ERR, 0, {tag, "_err_clear"});
            settle();
            tick(); mem_ack = 1'b0; ld_ctl = '0;
        end
        m_busy = 1'b0;
        if (!wr) m_mdr = data;
        chk(K_BUSY, 0, {tag, "_done_busy"});
        chk(K_REQ, 0, {tag, "_done_req"});
        chk(K_WDATA, m_mdr, {tag, "_mdr"});
        settle();
        tick();
        src_sel = sc(SRC_MDR);
        chk(K_BUS, data, {tag, "_bus_mdr"});
        settle();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        src_sel = 6'd5;
        chk(K_BUS, 0, "rst_bus_r5"); chk(K_REQ, 0, "rst_req"); chk(K_BUSY, 0, "rst_busy");
        chk(K_ERR, 0, "rst_err"); chk(K_CON, 0, "rst_con"); chk(K_OUT, 0, "rst_out");
        chk(K_IR, 0, "rst_ir"); chk(K_Y, 0, "rst_y"); chk(K_WE, 0, "rst_we");
        settle();
        clr = 1'b1;
        tick();

        // Register transfer through the input port, R0 gating
        in_port = 32'hDEADBEEF; tick();
        src_sel = sc(SRC_INPORT); reg_ld = 16'h0009; tick(); reg_ld = '0;
        src_sel = 6'd3; chk(K_BUS, 32'hDEADBEEF, "r3_xfer"); settle();
        src_sel = 6'd0; ba_out = 1'b1; chk(K_BUS, 0, "r0_ba_out"); settle();
        ba_out = 1'b0; chk(K_BUS, 32'hDEADBEEF, "r0_plain"); settle();

        // Simultaneous loads share one bus value
        in_port = 32'h13572468; tick();
        src_sel = sc(SRC_INPORT); reg_ld = 16'h0080;
        ld_ctl = 9'((1 << LD_Y) | (1 << LD_OUT) | (1 << LD_HI)); tick(); idle_strobes();
        chk(K_Y, 32'h13572468, "multi_y"); chk(K_OUT, 32'h13572468, "multi_out");
        src_sel = 6'd7; chk(K_BUS, 32'h13572468, "multi_r7"); settle();
        src_sel = sc(SRC_HI); chk(K_BUS, 32'h13572468, "multi_hi"); settle();
        src_sel = 6'(NR + 8); chk(K_BUS, 0, "src_out_of_range"); settle();

        // PC wrap and load-over-increment priority
        in_port = 32'hFFFFFFFF; tick();
        src_sel = sc(SRC_INPORT); ld_ctl = 9'(1 << LD_PC); tick(); ld_ctl = '0;
        inc_pc = 1'b1; tick(); inc_pc = 1'b0;
        src_sel = sc(SRC_PC); chk(K_BUS, 0, "pc_wrap"); settle();
        in_port = 32'h55; tick();
        src_sel = sc(SRC_INPORT); ld_ctl = 9'(1 << LD_PC); inc_pc = 1'b1; tick(); ld_ctl = '0;
        tick(); inc_pc = 1'b0;
        src_sel = sc(SRC_PC); chk(K_BUS, 32'h56, "pc_load_then_inc"); settle();

        // Z takes the ALU result, not the bus
        alu_zhi = 32'hA5A5_0001; alu_zlo = 32'h5A5A_0002;
        ld_ctl = 9'(1 << LD_Z); tick(); ld_ctl = '0;
        src_sel = sc(SRC_ZHI); chk(K_BUS, 32'hA5A5_0001, "zhi"); settle();
        src_sel = sc(SRC_ZLO); chk(K_BUS, 32'h5A5A_0002, "zlo"); settle();

        // CON with cond 11 (negative) then 00 (zero)
        in_port = 32'h0018_0000; tick();
        src_sel = sc(SRC_INPORT); ld_ctl = 9'(1 << LD_IR); tick(); ld_ctl = '0;
        chk(K_IR, 32'h0018_0000, "ir_load"); settle();
        in_port = 32'h8000_0000; tick();
        con_in = 1'b1; tick(); con_in = 1'b0;
        chk(K_CON, 1, "con_neg_true"); settle();
        c_ext = '0; src_sel = sc(SRC_CEXT); con_in = 1'b1; tick(); con_in = 1'b0;
        chk(K_CON, 0, "con_neg_zero"); settle();
        in_port = '0; src_sel = sc(SRC_INPORT); tick();
        ld_ctl = 9'(1 << LD_IR); tick(); ld_ctl = '0;
        src_sel = sc(SRC_CEXT); con_in = 1'b1; tick(); con_in = 1'b0;
        chk(K_CON, 1, "con_zero_true"); settle();

        // Memory: 3 wait-state read, zero-latency read, write
        mem_txn(1'b0, 9'h01A, 3, 32'h0000_1234, "rd3");
        mem_txn(1'b0, 9'h1F0, 0, 32'hCAFE_F00D, "rd0");
        mem_txn(1'b1, 9'h0C3, 2, 32'h0BAD_BEEF, "wr2");

        // Timeout on an unacknowledged write
        mem_wr = 1'b1; tick(); mem_wr = 1'b0;
        m_busy = 1'b1; busy_q.push_back(TMO);
        for (int c = 1; c <= TMO; c++) begin
            chk(K_REQ, 1, "tmo_req_held"); settle(); tick();
        end
        m_busy = 1'b0; m_err = 1'b1;
        chk(K_REQ, 0, "tmo_req_drop"); chk(K_ERR, 1, "tmo_err"); chk(K_BUSY, 0, "tmo_busy");
        settle(); tick();
        chk(K_ERR, 1, "tmo_err_sticky"); chk(K_WDATA, 32'h0BAD_BEEF, "tmo_mdr_kept"); settle();
        mem_txn(1'b0, 9'h044, 1, 32'h7777_0000, "rd_after_tmo");

        // Simultaneous read and write: error, no transaction
        mem_rd = 1'b1; mem_wr = 1'b1; tick(); mem_rd = 1'b0; mem_wr = 1'b0;
        chk(K_ERR, 1, "rdwr_err"); chk(K_REQ, 0, "rdwr_no_req"); settle();
        mem_txn(1'b0, 9'h100, 2, 32'h2468_ACE0, "rd_after_rdwr");

        // Randomised register/bus traffic with stray acks
        for (int it = 0; it < 300; it++) begin
            in_port = $urandom; alu_zhi = $urandom; alu_zlo = $urandom;
            c_ext = ($urandom_range(0, 3) == 0) ? '0 : 32'($urandom);
            src_sel = 6'($urandom_range(0, NR + 8)); ba_out = 1'($urandom_range(0, 1));
            reg_ld = 16'($urandom) & 16'($urandom);
            ld_ctl = 9'($urandom) & 9'($urandom);
            inc_pc = 1'($urandom_range(0, 1)); con_in = 1'($urandom_range(0, 1));
            mem_ack = ($urandom_range(0, 7) == 0); mem_rdata = $urandom;
            tick();
            idle_strobes();
            src_sel = 6'($urandom_range(0, NR + 8)); ba_out = 1'($urandom_range(0, 1));
            chk(K_BUS, model_bus(src_sel, ba_out), "rnd_bus");
            chk(K_CON, 32'(m_con), "rnd_con");
            chk(K_Y, m_y, "rnd_y");
            chk(K_OUT, m_out, "rnd_out");
            chk(K_IR, m_ir, "rnd_ir");
            chk(K_ADDR, 32'(m_mar), "rnd_mar");
            chk(K_WDATA, m_mdr, "rnd_mdr");
            chk(K_BUSY, 0, "rnd_idle");
            settle();
        end

        // Reset in the middle of a transaction
        mem_rd = 1'b1; tick(); mem_rd = 1'b0;
        busy_q.push_back(-1);
        tick();
        clr = 1'b0; src_sel = 6'd5; ba_out = 1'b0;
        #1;
        model_reset();
        chk(K_REQ, 0, "midrst_req"); chk(K_BUSY, 0, "midrst_busy");
        chk(K_BUS, 0, "midrst_bus_r5"); chk(K_ERR, 0, "midrst_err");
        chk(K_OUT, 0, "midrst_out"); chk(K_WDATA, 0, "midrst_mdr");
        settle();
        clr = 1'b1;
        tick();
        mem_txn(1'b0, 9'h0AA, 1, 32'h1111_2222, "rd_after_rst");

        settle();
        settle();
        if (busy_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL busy_pending: got %0d outstanding expected 0", busy_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
